// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: reset vector and fetch FSM state encodings.
package inst_fetch_ctrl_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction bus: one request channel (req/addr_ok) and one reply channel (data_ok/rdata).
interface inst_fetch_ctrl_if;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: owns pcF, issues one instruction-bus request at a time and
// drops the reply of any request that a redirect has overtaken.
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               pc_next,
   input  logic                      redirectM,
   input  logic                      stallF,
   inst_fetch_ctrl_if.master         bus,
   output logic [31:0]               pcF,
   output logic [31:0]               instrF,
   output logic                      instF_valid,
   output logic                      i_stall
);

   fetch_state_e state, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  pc_d;
   logic [31:0]  instr_d;
   logic         cancel, cancel_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // A redirect always retargets pcF; a reply that arrives while cancel is set
   // (or together with the redirect) is discarded and the new pcF is refetched.
   always_comb begin
      state_d  = state;
      pc_d     = pcF;
      addr_d   = addr_q;
      instr_d  = instrF;
      cancel_d = cancel;
      if (redirectM) begin
         pc_d = pc_next;
      end
      case (state)
         IDLE: begin
            addr_d  = pc_d;
            state_d = REQ;
         end
         REQ: begin
            if (redirectM) begin
               cancel_d = 1'b1;
            end
            if (bus.inst_addr_ok) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.inst_data_ok) begin
               if (cancel || redirectM) begin
                  cancel_d = 1'b0;
                  addr_d   = pc_d;
                  state_d  = REQ;
               end else begin
                  instr_d = bus.inst_rdata;
                  state_d = HOLD;
               end
            end else if (redirectM) begin
               cancel_d = 1'b1;
            end
         end
         HOLD: begin
            if (!stallF || redirectM) begin
               pc_d    = pc_next;
               addr_d  = pc_next;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcF    <= RESET_PC;
         addr_q <= RESET_PC;
         instrF <= 32'h0;
         cancel <= 1'b0;
      end else begin
         pcF    <= pc_d;
         addr_q <= addr_d;
         instrF <= instr_d;
         cancel <= cancel_d;
      end
   end

   assign bus.inst_req  = (state == REQ);
   assign bus.inst_addr = addr_q;
   assign instF_valid   = (state == HOLD);
   assign i_stall       = (state != HOLD);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: stimulus queues expected bus addresses and
// fetched words; independent monitors pop and compare them as the DUT presents them.
module tb_inst_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] pc_next;
   logic        redirectM;
   logic        stallF;
   logic [31:0] pcF;
   logic [31:0] instrF;
   logic        instF_valid;
   logic        i_stall;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_instr_q[$];

   inst_fetch_ctrl_if bus ();

   inst_fetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .pc_next     (pc_next),
      .redirectM   (redirectM),
      .stallF      (stallF),
      .bus         (bus),
      .pcF         (pcF),
      .instrF      (instrF),
      .instF_valid (instF_valid),
      .i_stall     (i_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // One clock cycle with the given inputs; returns 1 time unit after the edge.
   task automatic applyStimulus(input logic a_ok, input logic d_ok, input logic [31:0] rd,
                                input logic redir, input logic [31:0] pn, input logic st);
      bus.inst_addr_ok = a_ok;
      bus.inst_data_ok = d_ok;
      bus.inst_rdata   = rd;
      redirectM        = redir;
      pc_next          = pn;
      stallF           = st;
      @(posedge clk);
      #1;
   endtask

   task automatic expectFetch(input logic [31:0] pc, input logic [31:0] instr);
      exp_pc_q.push_back(pc);
      exp_instr_q.push_back(instr);
   endtask

   // Accepted bus requests must match the queued addresses in order.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.inst_req && bus.inst_addr_ok) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_request actual=%h required=none", bus.inst_addr);
            end else begin
               checkOutput("request_addr", bus.inst_addr, exp_addr_q.pop_front());
            end
         end
      end
   end

   // Each rising instF_valid must deliver the next queued (pc, instr) pair.
   initial begin
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (instF_valid && !prev_valid) begin
            if (exp_pc_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_fetch actual=%h/%h required=none", pcF, instrF);
            end else begin
               checkOutput("fetch_pc", pcF, exp_pc_q.pop_front());
               checkOutput("fetch_instr", instrF, exp_instr_q.pop_front());
            end
         end
         prev_valid = instF_valid;
      end
   end

   initial begin
      rst              = 1'b1;
      pc_next          = 32'h0;
      redirectM        = 1'b0;
      stallF           = 1'b0;
      bus.inst_addr_ok = 1'b0;
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
      #2;
      checkOutput("rst_pcF", pcF, 32'hBFC0_0000);
      checkOutput("rst_addr", bus.inst_addr, 32'hBFC0_0000);
      checkOutput("rst_req", {31'b0, bus.inst_req}, 32'h0);
      checkOutput("rst_instrF", instrF, 32'h0);
      checkOutput("rst_valid", {31'b0, instF_valid}, 32'h0);
      checkOutput("rst_istall", {31'b0, i_stall}, 32'h1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Test 1: first fetch after reset, immediate addr_ok, data_ok one cycle later
      exp_addr_q.push_back(32'hBFC0_0000);
      expectFetch(32'hBFC0_0000, 32'h2408_0001);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1);
      checkOutput("t1_req", {31'b0, bus.inst_req}, 32'h1);
      checkOutput("t1_istall", {31'b0, i_stall}, 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1);
      checkOutput("t1_wait_valid", {31'b0, instF_valid}, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h2408_0001, 1'b0, 32'hBFC0_0004, 1'b1);
      checkOutput("t1_valid", {31'b0, instF_valid}, 32'h1);
      checkOutput("t1_istall", {31'b0, i_stall}, 32'h0);

      // Test 2: hold under stallF, then release to pc_next
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1);
         checkOutput("t2_pcF", pcF, 32'hBFC0_0000);
         checkOutput("t2_instrF", instrF, 32'h2408_0001);
         checkOutput("t2_valid", {31'b0, instF_valid}, 32'h1);
         checkOutput("t2_req", {31'b0, bus.inst_req}, 32'h0);
      end
      exp_addr_q.push_back(32'hBFC0_0004);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b0);
      checkOutput("t2_rel_pcF", pcF, 32'hBFC0_0004);
      checkOutput("t2_rel_req", {31'b0, bus.inst_req}, 32'h1);

      // Test 3: redirect in WAIT, stale reply two cycles later is dropped
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC0_0008, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380, 1'b0);
      checkOutput("t3_pcF", pcF, 32'hBFC0_0380);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0384, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'hBFC0_0384, 1'b0);
      checkOutput("t3_valid", {31'b0, instF_valid}, 32'h0);
      checkOutput("t3_addr", bus.inst_addr, 32'hBFC0_0380);
      exp_addr_q.push_back(32'hBFC0_0380);
      expectFetch(32'hBFC0_0380, 32'h3C08_8000);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC0_0384, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h3C08_8000, 1'b0, 32'hBFC0_0384, 1'b1);

      // Test 4: redirect in REQ while addr_ok stays low for three cycles
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0384, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         checkOutput("t4_addr_hold", bus.inst_addr, 32'hBFC0_0384);
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h8000_0004, 1'b0);
      end
      checkOutput("t4_pcF", pcF, 32'h8000_0000);
      exp_addr_q.push_back(32'hBFC0_0384);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0004, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h8000_0004, 1'b0);
      checkOutput("t4_refetch_addr", bus.inst_addr, 32'h8000_0000);
      exp_addr_q.push_back(32'h8000_0000);
      expectFetch(32'h8000_0000, 32'h2409_0002);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0004, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h2409_0002, 1'b0, 32'h8000_0004, 1'b1);

      // Test 5: two redirects in one WAIT -> one cancel, last target wins
      exp_addr_q.push_back(32'h8000_0004);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h8000_0004, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0008, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0200, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h8000_0204, 1'b0);
      checkOutput("t5_refetch_addr", bus.inst_addr, 32'h8000_0200);
      exp_addr_q.push_back(32'h8000_0200);
      expectFetch(32'h8000_0200, 32'h2409_0003);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0204, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h2409_0003, 1'b0, 32'h8000_0204, 1'b1);

      // Test 6: asynchronous reset while a request is outstanding
      exp_addr_q.push_back(32'h8000_0204);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h8000_0204, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0208, 1'b0);
      bus.inst_addr_ok = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_pcF", pcF, 32'hBFC0_0000);
      checkOutput("t6_addr", bus.inst_addr, 32'hBFC0_0000);
      checkOutput("t6_req", {31'b0, bus.inst_req}, 32'h0);
      checkOutput("t6_instrF", instrF, 32'h0);
      checkOutput("t6_valid", {31'b0, instF_valid}, 32'h0);
      checkOutput("t6_istall", {31'b0, i_stall}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_addr_q.push_back(32'hBFC0_0000);
      expectFetch(32'hBFC0_0000, 32'h2408_0001);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h2408_0001, 1'b0, 32'hBFC0_0004, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1);

      checkOutput("pending_addr", exp_addr_q.size(), 32'h0);
      checkOutput("pending_fetch", exp_pc_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
